// File: rtl/float_fixed_pkg.sv
// Shared types and helpers for the float-to-fixed converter: FSM states,
// operand classes, exponent bias and fixed-point saturation limits.
package float_fixed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ALIGN,
        ROUND,
        PACK,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    function automatic int calc_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Largest positive value of a signed fix_w-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] sat_pos_limit(input int fix_w);
        return (64'd1 << (fix_w - 1)) - 64'd1;
    endfunction

    // Most negative value of a signed fix_w-bit word, sign-extended to 64 bits.
    function automatic logic [63:0] sat_neg_limit(input int fix_w);
        return ~64'd0 << (fix_w - 1);
    endfunction

endpackage

// File: rtl/float_to_fixed_conv_if.sv
// Start/acknowledge handshake, operand and result bundle of the float-to-fixed
// converter; the controller side uses the slave modport.
interface float_to_fixed_conv_if #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int FIX_W = 32
);
    logic              Begin_FSM_FF;
    logic              RST_FSM_FF;
    logic [EW+MW:0]    Data_in;
    logic [FIX_W-1:0]  Data_out;
    logic              ACK_FF;
    logic              BUSY;
    logic              OVF;
    logic              UNF;
    logic              NAN;

    modport master (
        output Begin_FSM_FF,
        output RST_FSM_FF,
        output Data_in,
        input  Data_out,
        input  ACK_FF,
        input  BUSY,
        input  OVF,
        input  UNF,
        input  NAN
    );

    modport slave (
        input  Begin_FSM_FF,
        input  RST_FSM_FF,
        input  Data_in,
        output Data_out,
        output ACK_FF,
        output BUSY,
        output OVF,
        output UNF,
        output NAN
    );

endinterface

// File: rtl/float_align_shifter.sv
// Combinational bidirectional barrel shifter placing the significand at the
// fixed-point binary point; reports guard/sticky on right shifts and overflow.
module float_align_shifter #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int FIX_W = 32
) (
    input  logic [MW:0]          sig,
    input  logic signed [EW+1:0] k,
    output logic [FIX_W-1:0]     mag,
    output logic                 guard,
    output logic                 sticky,
    output logic                 pre_ovf
);

    localparam int SW = FIX_W + MW + 1;
    localparam int GW = MW + 3;

    logic signed [31:0] k_ext;
    logic [31:0]        n;
    logic [SW-1:0]      wide;
    logic [MW+GW:0]     rsh;
    logic               huge;
    logic               excess;

    always_comb begin
        k_ext  = 32'(k);
        n      = 32'(-k_ext);
        wide   = '0;
        rsh    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        huge   = 1'b0;
        if (k_ext >= 0) begin
            if (k_ext >= FIX_W) begin
                huge = 1'b1;
            end else begin
                wide = SW'(sig) << k_ext;
            end
        end else if (n > 32'(MW + 2)) begin
            sticky = 1'b1;
        end else begin
            // The GW zero bits below the significand catch everything shifted out.
            rsh    = {sig, {GW{1'b0}}} >> n;
            wide   = SW'(rsh[MW+GW:GW]);
            guard  = rsh[GW-1];
            sticky = |rsh[GW-2:0];
        end
        pre_ovf = huge | (|wide[SW-1:FIX_W-1]);
        excess  = huge | (|wide[SW-1:FIX_W]);
        // Bits lost above the word force all-ones so the packer can never
        // mistake a large value for the exact negative limit.
        mag = excess ? '1 : wide[FIX_W-1:0];
    end

endmodule

// File: rtl/float_to_fixed_conv.sv
// Float-to-fixed converter: six-state controller with align/round/pack datapath.
// Define FLOAT_TO_FIXED_RNE_EN for round-to-nearest-even, else truncation.
module float_to_fixed_conv
    import float_fixed_pkg::*;
#(
    parameter int EW     = 8,
    parameter int MW     = 23,
    parameter int FIX_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST_FF,
    float_to_fixed_conv_if.slave  bus
);

    localparam int                     BIAS     = calc_bias(EW);
    localparam logic [FIX_W-1:0]       POS_LIM  = FIX_W'(sat_pos_limit(FIX_W));
    localparam logic [FIX_W-1:0]       NEG_LIM  = FIX_W'(sat_neg_limit(FIX_W));
    localparam logic [FIX_W:0]         NEG_MAG  = {1'b0, NEG_LIM};
    localparam logic [EW-1:0]          EXP_ONES = '1;
    localparam logic signed [EW+1:0]   K_OFF    = (EW+2)'(BIAS - FRAC_W + MW);

    state_t            state_reg;
    op_class_t         cls_reg;
    logic [EW+MW:0]    operand_reg;
    logic [FIX_W-1:0]  mag_reg;
    logic              pre_ovf_reg;
    logic [FIX_W:0]    rmag_reg;
    logic [FIX_W-1:0]  data_out_reg;
    logic              ack_reg;
    logic              busy_reg;
    logic              ovf_reg;
    logic              unf_reg;
    logic              nan_reg;

    logic              op_sign;
    logic [EW-1:0]     op_exp;
    logic [MW-1:0]     op_man;
    logic [MW:0]       sig;
    logic signed [EW+1:0] k;
    op_class_t         cls_next;

    logic [FIX_W-1:0]  sh_mag;
    logic              sh_guard;
    logic              sh_sticky;
    logic              sh_pre_ovf;
    logic              round_inc;

    logic [FIX_W-1:0]  pack_data;
    logic              pack_ovf;
    logic              pack_unf;
    logic              pack_nan;
    logic [FIX_W-1:0]  mag_t;
    logic [FIX_W-1:0]  signed_val;
    logic              ovf_fin;

    assign op_sign = operand_reg[EW+MW];
    assign op_exp  = operand_reg[EW+MW-1:MW];
    assign op_man  = operand_reg[MW-1:0];
    assign sig     = {1'b1, op_man};
    assign k       = $signed({2'b00, op_exp}) - K_OFF;

    always_comb begin
        cls_next = CLS_NORMAL;
        if (op_exp == '0) begin
            cls_next = CLS_ZERO;
        end else if (op_exp == EXP_ONES) begin
            cls_next = (op_man == '0) ? CLS_INF : CLS_NAN;
        end
    end

    float_align_shifter #(
        .EW    (EW),
        .MW    (MW),
        .FIX_W (FIX_W)
    ) u_shifter (
        .sig     (sig),
        .k       (k),
        .mag     (sh_mag),
        .guard   (sh_guard),
        .sticky  (sh_sticky),
        .pre_ovf (sh_pre_ovf)
    );

`ifdef FLOAT_TO_FIXED_RNE_EN
    logic guard_reg;
    logic sticky_reg;

    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            guard_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else if (state_reg == ALIGN) begin
            guard_reg  <= sh_guard;
            sticky_reg <= sh_sticky;
        end
    end

    // Round up above half, or on an exact half when the magnitude is odd.
    assign round_inc = guard_reg & (sticky_reg | mag_reg[0]);
`else
    // Truncation toward zero: the bits shifted out play no part.
    logic unused_lost;
    assign unused_lost = sh_guard | sh_sticky;
    assign round_inc   = 1'b0;
`endif

    always_comb begin
        mag_t      = rmag_reg[FIX_W-1:0];
        signed_val = op_sign ? (~mag_t + FIX_W'(1)) : mag_t;
        // A magnitude of exactly 2^(FIX_W-1) is representable when negative.
        ovf_fin    = (pre_ovf_reg | rmag_reg[FIX_W] | rmag_reg[FIX_W-1])
                     & ~(op_sign & (rmag_reg == NEG_MAG));
        pack_data  = '0;
        pack_ovf   = 1'b0;
        pack_unf   = 1'b0;
        pack_nan   = 1'b0;
        case (cls_reg)
            CLS_ZERO: begin
                pack_data = '0;
            end
            CLS_NAN: begin
                pack_data = POS_LIM;
                pack_nan  = 1'b1;
            end
            CLS_INF: begin
                pack_data = op_sign ? NEG_LIM : POS_LIM;
                pack_ovf  = 1'b1;
            end
            default: begin
                if (ovf_fin) begin
                    pack_data = op_sign ? NEG_LIM : POS_LIM;
                    pack_ovf  = 1'b1;
                end else begin
                    pack_data = signed_val;
                    pack_unf  = (rmag_reg == '0);
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            state_reg    <= IDLE;
            cls_reg      <= CLS_ZERO;
            operand_reg  <= '0;
            mag_reg      <= '0;
            pre_ovf_reg  <= 1'b0;
            rmag_reg     <= '0;
            data_out_reg <= '0;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
            nan_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.Begin_FSM_FF) begin
                        operand_reg <= bus.Data_in;
                        busy_reg    <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    cls_reg   <= cls_next;
                    state_reg <= ALIGN;
                end
                ALIGN: begin
                    mag_reg     <= sh_mag;
                    pre_ovf_reg <= sh_pre_ovf;
                    state_reg   <= ROUND;
                end
                ROUND: begin
                    rmag_reg  <= {1'b0, mag_reg} + (FIX_W+1)'(round_inc);
                    state_reg <= PACK;
                end
                PACK: begin
                    data_out_reg <= pack_data;
                    ovf_reg      <= pack_ovf;
                    unf_reg      <= pack_unf;
                    nan_reg      <= pack_nan;
                    state_reg    <= DONE;
                end
                DONE: begin
                    // A start arriving with the clear is dropped; it must be re-issued in IDLE.
                    if (bus.RST_FSM_FF) begin
                        ack_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        ack_reg <= 1'b1;
                    end
                end
                default: begin
                    ack_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.Data_out = data_out_reg;
    assign bus.ACK_FF   = ack_reg;
    assign bus.BUSY     = busy_reg;
    assign bus.OVF      = ovf_reg;
    assign bus.UNF      = unf_reg;
    assign bus.NAN      = nan_reg;

endmodule

// File: doc/float_to_fixed_conv.md
# float_to_fixed_conv

Parametrised float-to-fixed converter: a single-cycle-sampled, fixed-latency controller with its own datapath. It converts an IEEE-754-style binary float of configurable exponent and mantissa width into a signed two's-complement fixed-point word of configurable total and fractional width. It saturates on overflow and classifies special values. It replaces the 32-bit single-precision float-to-fixed FSM plus external shifter in the float-to-fixed conversion path, and keeps the same start / acknowledge / FSM-reset handshake.

## Interface
- EW, 8, exponent width; bias = 2^(EW-1)-1
- MW, 23, stored mantissa width
- FIX_W, 32, fixed-point output width (signed)
- FRAC_W, 16, fractional bits of output; 0 ≤ FRAC_W < FIX_W
- CLK  in  1  system clock, rising edge
- RST_FF  in  1  synchronous, active-high reset
- Begin_FSM_FF  in  1  start request, sampled only in IDLE
- RST_FSM_FF  in  1  acknowledge clear; releases DONE
- Data_in  in  1+EW+MW  float operand {sign, exp, mantissa}
- Data_out  out  FIX_W  fixed-point result; reset 0
- ACK_FF  out  1  result valid, held in DONE; reset 0
- BUSY  out  1  high in every state except IDLE; reset 0
- OVF  out  1  result saturated (finite or Inf overflow); reset 0
- UNF  out  1  nonzero finite input produced 0; reset 0
- NAN  out  1  input was NaN; reset 0

## Operation
- States: IDLE → LOAD → ALIGN → ROUND → PACK → DONE → IDLE.
- IDLE: when Begin_FSM_FF=1, capture Data_in into the operand register and go to LOAD. Otherwise stay in IDLE.
- LOAD: classify the operand.
  - e==0 (zero or subnormal, flushed): zero class.
  - e==all-ones, m==0: Inf class.
  - e==all-ones, m≠0: NaN class.
  - Otherwise: normal.
- ALIGN: sig = {1,m} (MW+1 bits); k = e − bias + FRAC_W − MW (signed, EW+2 bits).
  - k ≥ 0: left-shift sig by k. If any bit would land at or above position FIX_W−1, flag pre-overflow.
  - k < 0: right-shift by −k and keep guard (last bit out) and sticky (OR of the rest). −k > MW+2 gives magnitude 0, guard 0, sticky 1.
- ROUND: apply rounding per Configuration. A carry out of the rounding can cause overflow.
- PACK:
  - Negate the magnitude if the sign is 1.
  - Saturate positive results to 2^(FIX_W−1)−1. Saturate negative results to −2^(FIX_W−1); a magnitude of exactly 2^(FIX_W−1) with sign 1 is legal and does not set OVF.
  - Inf class: saturate by sign, OVF=1.
  - NaN class: Data_out = 2^(FIX_W−1)−1, NAN=1, OVF=0.
  - Zero class: Data_out=0, all flags 0. −0 → 0.
  - UNF=1 when the input is normal and the packed result is 0.
  - Register Data_out and the flags.
- DONE: ACK_FF=1. Data_out and the flags stay stable. Go to IDLE on RST_FSM_FF=1.
- Data_out and the flags hold their value through IDLE until the next PACK.

## Timing
- Latency: Begin_FSM_FF sampled at edge 0 → ACK_FF high after edge 5. The latency is the same for every operand class and for both macro settings.
- Throughput: one conversion per 6 + (cycles held in DONE) cycles.
- Begin_FSM_FF outside IDLE is ignored. Data_in is only sampled at the IDLE→LOAD edge.
- Begin_FSM_FF and RST_FSM_FF both high in DONE: go to IDLE and ignore the start. The start must be re-asserted in IDLE.
- RST_FSM_FF outside DONE is ignored.
- RST_FF at any cycle, including mid-conversion: on the next edge the state is IDLE and every output is 0.

## Configuration
- FLOAT_TO_FIXED_RNE_EN defined: round to nearest, ties to even, using guard, sticky and magnitude LSB.
- Undefined: truncate toward zero on the magnitude; guard and sticky are discarded. The ROUND state still exists as a pass-through cycle.

## Structure
- Shared package float_fixed_pkg:
  - state enum (IDLE, LOAD, ALIGN, ROUND, PACK, DONE)
  - operand-class enum (ZERO, NORMAL, INF, NAN)
  - function that computes the bias from EW
  - function that computes the FIX_W saturation limits
- One sub-module, float_align_shifter: a combinational bidirectional barrel shifter. Inputs: sig and signed k. Outputs: magnitude, guard, sticky, pre-overflow. The FSM, the rounding step and the packing step stay in the top level.

## Test plan
Defaults apply (EW=8, MW=23, FIX_W=32, FRAC_W=16).
- 0x3F800000 (1.0) → Data_out 0x00010000, flags 0, ACK_FF high exactly 5 edges after start.
- 0xC0200000 (−2.5) → 0xFFFD8000; 0x80000000 (−0) → 0x00000000.
- 0x47000000 (32768.0) → 0x7FFFFFFF, OVF=1; 0xC7000000 (−32768.0) → 0x80000000, OVF=0; 0xFF800000 (−Inf) → 0x80000000, OVF=1.
- 0x37400000 (0.75·2^-16):
  - RNE build → 0x00000001, UNF=0.
  - Truncating build → 0x00000000, UNF=1.
  - 0x37000000 (tie 0.5 LSB), RNE build → 0x00000000, UNF=1.
- 0x7FC00000 (NaN) → 0x7FFFFFFF, NAN=1, OVF=0.
- Handshake:
  - Pulse Begin_FSM_FF during ALIGN → ignored.
  - RST_FF asserted in ROUND → all outputs 0 and the state is IDLE on the next edge.
  - Begin_FSM_FF and RST_FSM_FF together in DONE → IDLE, no new conversion starts.
